// File: rtl/gate_delay_pkg.sv
// Shared constants and the delay clamp for the clocked gate delay line.
package gate_delay_pkg;

    localparam logic INV_BUF = 1'b0;
    localparam logic INV_NOT = 1'b1;

    // Maps a requested delay onto the implemented tap range 1..depth.
    function automatic int unsigned clamp_dly(input int unsigned dly, input int unsigned depth);
        if (dly == 0)
            return 1;
        else if (dly > depth)
            return depth;
        else
            return dly;
    endfunction

endpackage

// File: rtl/gate_delay_stage.sv
// One delay stage: WIDTH-bit data register plus valid bit, held when EN is low.
module gate_delay_stage
    import gate_delay_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             EN,
    input  logic [WIDTH-1:0] D,
    input  logic             V,
    output logic [WIDTH-1:0] Q,
    output logic             QV
);

    logic [WIDTH-1:0] data_q;
    logic             vld_q;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            data_q <= '0;
            vld_q  <= 1'b0;
        end else if (EN) begin
            data_q <= D;
            vld_q  <= V;
        end
    end

    assign Q  = data_q;
    assign QV = vld_q;

endmodule

// File: rtl/gate_delay_line.sv
// Clocked buffer/inverter whose output lags the input by a selectable 1..DEPTH cycles.
module gate_delay_line
    import gate_delay_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int DLY_W = $clog2(DEPTH + 1)
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             EN,
    input  logic             INV,
    input  logic [DLY_W-1:0] DLY,
    input  logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] X,
    output logic             X_VLD
);

    logic [WIDTH-1:0] cap_d;
    logic [WIDTH-1:0] stg_d [DEPTH];
    logic [WIDTH-1:0] s_q   [DEPTH];
    logic [DEPTH-1:0] vin_d;
    logic [DEPTH-1:0] v_q;
    logic [DLY_W-1:0] dly_d;
    logic [DLY_W-1:0] dly_q;

    // The transform is fixed at capture, so in-flight data ignores later INV changes.
    always_comb begin
        cap_d = A;
        case (INV)
            INV_BUF: cap_d = A;
            INV_NOT: cap_d = ~A;
            default: cap_d = A;
        endcase
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        if (i == 0) begin : g_head
            assign stg_d[i] = cap_d;
            assign vin_d[i] = 1'b1;
        end else begin : g_body
            assign stg_d[i] = s_q[i-1];
            assign vin_d[i] = v_q[i-1];
        end

        gate_delay_stage #(
            .WIDTH (WIDTH)
        ) u_stage (
            .CLK   (CLK),
            .RST_N (RST_N),
            .EN    (EN),
            .D     (stg_d[i]),
            .V     (vin_d[i]),
            .Q     (s_q[i]),
            .QV    (v_q[i])
        );
    end

    assign dly_d = DLY_W'(clamp_dly(32'(DLY), DEPTH));

    // Tap select tracks DLY every cycle, even while the pipeline is stalled.
    always_ff @(posedge CLK) begin
        if (!RST_N)
            dly_q <= DLY_W'(1);
        else
            dly_q <= dly_d;
    end

    always_comb begin
        X     = '0;
        X_VLD = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (dly_q == DLY_W'(i + 1)) begin
                X     = s_q[i];
                X_VLD = v_q[i];
            end
        end
    end

endmodule

// File: tb/tb_gate_delay_line.sv
// Directed self-checking bench for gate_delay_line (WIDTH=8, DEPTH=8).
module tb_gate_delay_line;

    logic       CLK;
    logic       RST_N;
    logic       EN;
    logic       INV;
    logic [3:0] DLY;
    logic [7:0] A;
    logic [7:0] X;
    logic       X_VLD;

    int n_chk;
    int n_fail;

    gate_delay_line #(
        .WIDTH (8),
        .DEPTH (8)
    ) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .EN    (EN),
        .INV   (INV),
        .DLY   (DLY),
        .A     (A),
        .X     (X),
        .X_VLD (X_VLD)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [7:0] ex, input logic ev);
        chk({tag, ".X"}, 32'(X), 32'(ex));
        chk({tag, ".VLD"}, 32'(X_VLD), 32'(ev));
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;

        // Reset with EN=1 active: reset must win.
        RST_N = 1'b0; EN = 1'b1; A = 8'hFF; INV = 1'b1; DLY = 4'd3;
        tick();
        chk_out("rst0", 8'h00, 1'b0);
        tick();
        chk_out("rst1", 8'h00, 1'b0);

        // Invert with DLY=3.
        RST_N = 1'b1; A = 8'h0F;
        tick();
        chk_out("inv_e0", 8'h00, 1'b0);
        A = 8'h00;
        tick();
        chk_out("inv_e1", 8'h00, 1'b0);
        tick();
        chk_out("inv_e2", 8'hF0, 1'b1);

        // Buffer, minimum delay.
        INV = 1'b0; DLY = 4'd1; A = 8'hA5;
        tick();
        chk_out("buf_d1", 8'hA5, 1'b1);

        // Stall with DLY=4.
        RST_N = 1'b0; EN = 1'b0;
        tick();
        RST_N = 1'b1; EN = 1'b1; DLY = 4'd4;
        A = 8'h01; tick();
        A = 8'h02; tick();
        A = 8'h03; tick();
        chk_out("stall_fill", 8'h00, 1'b0);
        A = 8'h00; tick();
        chk_out("stall_pre", 8'h01, 1'b1);
        EN = 1'b0; A = 8'hEE;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_out("stall_hold", 8'h01, 1'b1);
        end
        EN = 1'b1; A = 8'h00;
        tick();
        chk_out("stall_r1", 8'h02, 1'b1);
        tick();
        chk_out("stall_r2", 8'h03, 1'b1);

        // Delay change 2 -> 6 -> 2.
        RST_N = 1'b0; EN = 1'b0;
        tick();
        RST_N = 1'b1; EN = 1'b1; DLY = 4'd2;
        A = 8'h11; tick();
        chk_out("dc_e0", 8'h00, 1'b0);
        A = 8'h22; tick();
        chk_out("dc_e1", 8'h11, 1'b1);
        A = 8'h33; tick();
        chk_out("dc_e2", 8'h22, 1'b1);
        DLY = 4'd6;
        A = 8'h44; tick();
        chk("dc_e3.VLD", 32'(X_VLD), 32'd0);
        A = 8'h55; tick();
        chk("dc_e4.VLD", 32'(X_VLD), 32'd0);
        A = 8'h66; tick();
        chk_out("dc_e5", 8'h11, 1'b1);
        DLY = 4'd2;
        A = 8'h77; tick();
        chk_out("dc_e6", 8'h66, 1'b1);

        // Clamp: 0 acts as 1, 15 acts as 8.
        DLY = 4'd0; A = 8'h5A; tick();
        chk_out("clamp0", 8'h5A, 1'b1);
        DLY = 4'd15; A = 8'hC3; tick();
        chk_out("clamp15", 8'h22, 1'b1);

        // Mid-stream reset with EN=1.
        RST_N = 1'b0; A = 8'h99; tick();
        chk_out("mid_rst", 8'h00, 1'b0);
        chk("mid_rst.dly_q", 32'(dut.dly_q), 32'd1);
        RST_N = 1'b1; DLY = 4'd1; A = 8'hE7; tick();
        chk_out("post_rst", 8'hE7, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
